mul_ctrl: RTL and testbench

Sequencing controller for the repeated-addition multiplier datapath (A, B, P registers, adder, B decrementer, and the B zero/sign comparator). Accepts a start request, loads operands, then issues one accumulate-and-decrement per iteration until the comparator reports B equal to zero. Reports done or error back to the requester with a level handshake. It also bounds the iteration count so a runaway operand cannot stall the datapath.

---
 rtl/mul_ctrl.sv | 131 +++++++++++++
 tb/tb_mul_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mul_ctrl.sv
// mul_ctrl: sequencing FSM for the repeated-addition multiplier datapath.
// Strobes are registered from the next state so they line up exactly with the state register.
module mul_ctrl #(
   parameter int unsigned MAX_ITER = 65535,
   parameter int unsigned CW       = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          eqz,
   input  logic          neg,
   output logic          ldA,
   output logic          ldB,
   output logic          clrP,
   output logic          ldP,
   output logic          decB,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [CW-1:0] iter
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_A = 3'd1,
      LOAD_B = 3'd2,
      CHECK  = 3'd3,
      ADD    = 3'd4,
      DONE   = 3'd5,
      ERR    = 3'd6
   } state_t;

   localparam logic [CW-1:0] ITER_LIMIT = CW'(MAX_ITER);

   state_t state_r;
   state_t next_s;
   logic   ld_a_s, ld_b_s, clr_p_s, ld_p_s, dec_b_s, busy_s, done_s, err_s;

   // Next-state selection; a negative B outranks zero, which outranks the iteration limit
   always_comb begin
      next_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) next_s = LOAD_A;
            else       next_s = IDLE;
         end
         LOAD_A: next_s = LOAD_B;
         LOAD_B: next_s = CHECK;
         CHECK: begin
            if (neg)                     next_s = ERR;
            else if (eqz)                next_s = DONE;
            else if (iter == ITER_LIMIT) next_s = ERR;
            else                         next_s = ADD;
         end
         ADD: next_s = CHECK;
         DONE: begin
            if (start) next_s = DONE;
            else       next_s = IDLE;
         end
         ERR: begin
            if (start) next_s = ERR;
            else       next_s = IDLE;
         end
         default: next_s = IDLE;
      endcase
   end

   // Moore output decode of the state about to be entered
   always_comb begin
      ld_a_s  = 1'b0;
      ld_b_s  = 1'b0;
      clr_p_s = 1'b0;
      ld_p_s  = 1'b0;
      dec_b_s = 1'b0;
      busy_s  = 1'b0;
      done_s  = 1'b0;
      err_s   = 1'b0;
      case (next_s)
         IDLE: busy_s = 1'b0;
         LOAD_A: begin
            ld_a_s = 1'b1;
            busy_s = 1'b1;
         end
         LOAD_B: begin
            ld_b_s  = 1'b1;
            clr_p_s = 1'b1;
            busy_s  = 1'b1;
         end
         CHECK: busy_s = 1'b1;
         ADD: begin
            ld_p_s  = 1'b1;
            dec_b_s = 1'b1;
            busy_s  = 1'b1;
         end
         DONE:    done_s = 1'b1;
         ERR:     err_s  = 1'b1;
         default: busy_s = 1'b0;
      endcase
   end

   // State, registered strobes and the iteration counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         ldA     <= 1'b0;
         ldB     <= 1'b0;
         clrP    <= 1'b0;
         ldP     <= 1'b0;
         decB    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         iter    <= {CW{1'b0}};
      end else begin
         state_r <= next_s;
         ldA     <= ld_a_s;
         ldB     <= ld_b_s;
         clrP    <= clr_p_s;
         ldP     <= ld_p_s;
         decB    <= dec_b_s;
         busy    <= busy_s;
         done    <= done_s;
         err     <= err_s;
         // CHECK stops at the limit, so the increment can never wrap
         if (state_r == LOAD_A)   iter <= {CW{1'b0}};
         else if (state_r == ADD) iter <= iter + {{(CW-1){1'b0}}, 1'b1};
         else                     iter <= iter;
      end
   end

endmodule

// File: tb/tb_mul_ctrl.sv
// Bench for mul_ctrl: a behavioural A/B/P datapath feeds the comparator inputs, and each
// operation's per-edge strobe pattern is predicted from the operand value alone.
module tb_mul_ctrl;
   localparam int MAXI = 4;
   localparam int CW   = 16;

   logic          clk = 1'b0;
   logic          rst, start;
   logic          eqz, neg;
   logic          ldA, ldB, clrP, ldP, decB, busy, done, err;
   logic [CW-1:0] iter;

   int opa = 0, opb = 0;
   int am = 0, bm = 1, pm = 0;
   bit neg_force = 1'b0;
   int vectors = 0, miscompares = 0;

   mul_ctrl #(.MAX_ITER(MAXI), .CW(CW)) dut (
      .clk(clk), .rst(rst), .start(start), .eqz(eqz), .neg(neg),
      .ldA(ldA), .ldB(ldB), .clrP(clrP), .ldP(ldP), .decB(decB),
      .busy(busy), .done(done), .err(err), .iter(iter)
   );

   always #5 clk = ~clk;

   // datapath registers driven by the controller's strobes
   always @(posedge clk) begin
      if (ldA) am <= opa;
      if (ldB) bm <= opb;
      else if (decB) bm <= bm - 1;
      if (clrP) pm <= 0;
      else if (ldP) pm <= pm + am;
   end
   assign eqz = (bm == 0);
   assign neg = (bm < 0) || neg_force;

   wire [7:0] obs = {ldA, ldB, clrP, ldP, decB, busy, done, err};

   // expected {ldA,ldB,clrP,ldP,decB,busy,done,err} k edges after start is sampled
   function automatic logic [7:0] exp_vec(int k, int term, int adds, bit is_err);
      logic pulse;
      pulse = (k >= 3) && (k <= 2*adds + 1) && (k % 2 == 1);
      exp_vec = {k == 0, k == 1, k == 1, pulse, pulse, k < term,
                 (k >= term) && !is_err, (k >= term) && is_err};
   endfunction

   task automatic run_op(input int a, input int b, input bit pulse_start, input bit frc);
      int adds, term, exp_iter, hold;
      bit is_err;
      if (b < 0 || frc)   begin adds = 0;    is_err = 1'b1; end
      else if (b <= MAXI) begin adds = b;    is_err = 1'b0; end
      else                begin adds = MAXI; is_err = 1'b1; end
      term     = 2*adds + 3;
      exp_iter = adds;
      hold     = int'($urandom_range(3, 0));
      opa = a; opb = b; neg_force = frc;
      @(negedge clk); start = 1'b1;
      for (int k = 0; k <= term + hold; k++) begin
         @(posedge clk); #1;
         vectors++;
         if (obs !== exp_vec(k, term, adds, is_err)) begin
            miscompares++;
            $display("FAIL strobes a=%0d b=%0d edge=%0d: got %b want %b", a, b, k, obs,
                     exp_vec(k, term, adds, is_err));
         end
         if (k == term) begin
            vectors++;
            if (iter !== CW'(exp_iter)) begin
               miscompares++;
               $display("FAIL iter b=%0d: got %0d want %0d", b, iter, exp_iter);
            end
            if (!is_err) begin
               vectors++;
               if (pm != a*b) begin
                  miscompares++;
                  $display("FAIL product %0d*%0d: got %0d want %0d", a, b, pm, a*b);
               end
            end
         end
         if (pulse_start && k + 1 < term) start = 1'($urandom_range(1, 0));
         else                             start = 1'b1;
      end
      start = 1'b0; neg_force = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if (obs !== 8'h00 || iter !== CW'(exp_iter)) begin
         miscompares++;
         $display("FAIL release b=%0d: got %b iter %0d want 00000000 iter %0d", b, obs, iter,
                  exp_iter);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         vectors++;
         if (obs !== 8'h00 || iter !== '0) begin
            miscompares++;
            $display("FAIL reset: got %b iter %0d want 00000000 iter 0", obs, iter);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_directed();
      run_op(7, 3, 1'b0, 1'b0);
      run_op(9, 0, 1'b0, 1'b0);
      run_op(6, -5, 1'b0, 1'b0);
      run_op(2, 5, 1'b0, 1'b0);
      run_op(3, 4, 1'b0, 1'b0);
      run_op(5, 0, 1'b0, 1'b1);
   endtask

   task automatic test_reset_mid_add();
      opa = 4; opb = 3;
      @(negedge clk); start = 1'b1;
      for (int k = 0; k <= 5; k++) begin
         @(posedge clk); #1;
         vectors++;
         if (obs !== exp_vec(k, 9, 3, 1'b0)) begin
            miscompares++;
            $display("FAIL pre-reset edge=%0d: got %b want %b", k, obs, exp_vec(k, 9, 3, 1'b0));
         end
      end
      rst = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (obs !== 8'h00 || iter !== '0) begin
         miscompares++;
         $display("FAIL mid-add reset: got %b iter %0d want 00000000 iter 0", obs, iter);
      end
      rst = 1'b0; start = 1'b0;
      @(posedge clk); #1;
      run_op(6, 2, 1'b0, 1'b0);
   endtask

   task automatic test_start_pulsing();
      run_op(11, 3, 1'b1, 1'b0);
      run_op(8, 6, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 25; i++)
         run_op(int'($urandom_range(50, 0)), int'($urandom_range(10, 0)) - 3,
                1'($urandom_range(1, 0)), 1'b0);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_reset_mid_add();
      test_start_pulsing();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
